// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encodings
// and the default memory access latency.
package mem_arbiter_pkg;

    // Arbiter FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IACC = 2'd1,
        ARB_DACC = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    // Default fixed latency of the unified memory, in cycles.
    localparam int MEM_LAT_DEFAULT = 4;

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter with a zero flag. Used to time fixed-latency
// memory accesses; saturates at zero when decrementing.
module mem_lat_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority over decrement; stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported fixed-latency memory between
// instruction fetch (I-side) and load/store (D-side). Data wins by default;
// a fairness bit hands the next grant to fetch after a contested D access.
// All memory-side and ready outputs are decoded from registered state.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              fair_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_wr_q;
    logic              req_side_i_q;
    logic [DATA_W-1:0] i_data_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic d_req;
    logic grant_i;
    logic grant_d;
    logic in_acc;
    logic acc_last;
    logic cnt_zero;

    assign d_req    = d_rd | d_wr;
    assign in_acc   = (state_q == ARB_IACC) || (state_q == ARB_DACC);
    assign acc_last = in_acc && cnt_zero;

    // Access-latency timer: loaded with MEM_LAT-1 on grant, counts down
    // while the enables are held; zero marks the last access cycle.
    mem_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (grant_i | grant_d),
        .load_val_i (CNT_LOAD),
        .dec_i      (in_acc),
        .zero_o     (cnt_zero)
    );

    // Next-state and grant decode; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req && (!i_req || !fair_q)) begin
                    grant_d = 1'b1;
                    state_d = ARB_DACC;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_d = ARB_IACC;
                end
            end
            ARB_IACC, ARB_DACC: begin
                if (cnt_zero) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's address/data/op; a simultaneous rd+wr is a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wr_q     <= 1'b0;
            req_side_i_q <= 1'b0;
        end else if (grant_d) begin
            req_addr_q   <= d_addr;
            req_wdata_q  <= d_wdata;
            req_wr_q     <= d_wr;
            req_side_i_q <= 1'b0;
        end else if (grant_i) begin
            req_addr_q   <= i_addr;
            req_wdata_q  <= '0;
            req_wr_q     <= 1'b0;
            req_side_i_q <= 1'b1;
        end
    end

    // Fairness: fetch goes first after a D access that kept fetch waiting;
    // data goes first again once a fetch completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fair_q <= 1'b0;
        end else if (acc_last) begin
            if (req_side_i_q) begin
                fair_q <= 1'b0;
            end else if (i_req) begin
                fair_q <= 1'b1;
            end
        end
    end

    // Capture read data in the last access cycle; writes leave d_rdata alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else if (acc_last) begin
            if (state_q == ARB_IACC) begin
                i_data_q <= mem_rdata;
            end else if (!req_wr_q) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign busy      = (state_q != ARB_IDLE);
    assign mem_re    = (state_q == ARB_IACC) || ((state_q == ARB_DACC) && !req_wr_q);
    assign mem_we    = (state_q == ARB_DACC) && req_wr_q;
    assign mem_addr  = in_acc ? req_addr_q : '0;
    assign mem_wdata = mem_we ? req_wdata_q : '0;
    assign i_rdy     = (state_q == ARB_RESP) && req_side_i_q;
    assign d_rdy     = (state_q == ARB_RESP) && !req_side_i_q;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: one instance at MEM_LAT=4 and one at
// MEM_LAT=1, each backed by a small memory model that only drives valid
// read data in the last cycle of an access.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A, MEM_LAT = 4 ----------------
    logic        i_req, i_rdy, d_rd, d_wr, d_rdy, mem_re, mem_we, busy;
    logic [15:0] i_addr, i_data, d_addr, d_wdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.MEM_LAT(4), .ADDR_W(16), .DATA_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rdata(d_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [15:0] mem_a [256];
    int          acc_a;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_a[8'h10] <= 16'hB123;
            acc_a        <= 0;
        end else begin
            if (mem_we) mem_a[mem_addr[7:0]] <= mem_wdata;
            acc_a <= (mem_re || mem_we) ? acc_a + 1 : 0;
        end
    end
    assign mem_rdata = (mem_re && acc_a == 3) ? mem_a[mem_addr[7:0]] : 16'hDEAD;

    // ---------------- instance B, MEM_LAT = 1 ----------------
    logic        b_i_req, b_i_rdy, b_d_rd, b_d_wr, b_d_rdy, b_mem_re, b_mem_we, b_busy;
    logic [15:0] b_i_addr, b_i_data, b_d_addr, b_d_wdata, b_d_rdata;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdy(b_i_rdy), .i_data(b_i_data),
        .d_rd(b_d_rd), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdy(b_d_rdy), .d_rdata(b_d_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    logic [15:0] mem_b [256];
    int          acc_b;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_b[8'h10] <= 16'hB123;
            acc_b        <= 0;
        end else begin
            if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
            acc_b <= (b_mem_re || b_mem_we) ? acc_b + 1 : 0;
        end
    end
    assign b_mem_rdata = (b_mem_re && acc_b == 0) ? mem_b[b_mem_addr[7:0]] : 16'hDEAD;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on instance A starting from IDLE, with the
    // request dropped in the RESP cycle.
    task automatic run_a(input string tag, input bit is_i, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data);
        i_req = is_i; i_addr = addr;
        d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wdata;
        chk({tag, "_t0_en"}, 32'({mem_re, mem_we}), 32'b00);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk({tag, "_en"},   32'({mem_re, mem_we}), wr ? 32'b01 : 32'b10);
            chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
            chk({tag, "_rdy0"}, 32'({i_rdy, d_rdy}), 32'b00);
            if (wr) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
        end
        tick();
        chk({tag, "_rdy"},    32'({i_rdy, d_rdy}), is_i ? 32'b10 : 32'b01);
        chk({tag, "_resp_en"}, 32'({mem_re, mem_we}), 32'b00);
        chk({tag, "_data"},   32'(is_i ? i_data : d_rdata), 32'(exp_data));
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        tick();
        chk({tag, "_idle"}, 32'({busy, i_rdy, d_rdy}), 32'b000);
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against hangs.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_addr;
        bit          rdy_seen;

        i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        b_i_req = 0; b_i_addr = 0; b_d_rd = 0; b_d_wr = 0; b_d_addr = 0; b_d_wdata = 0;

        // Reset with random request inputs.
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            i_req = 1'($urandom); i_addr = 16'($urandom);
            d_rd = 1'($urandom); d_wr = 1'($urandom);
            d_addr = 16'($urandom); d_wdata = 16'($urandom);
            b_i_req = 1'($urandom); b_d_wr = 1'($urandom);
            tick();
            chk("rst_outs_a", 32'(|{i_rdy, i_data, d_rdy, d_rdata, mem_re, mem_we,
                                    mem_addr, mem_wdata}), 32'd0);
            chk("rst_busy_a", 32'(busy), 32'd0);
            chk("rst_outs_b", 32'(|{b_i_rdy, b_i_data, b_d_rdy, b_d_rdata, b_mem_re,
                                    b_mem_we, b_mem_addr, b_mem_wdata, b_busy}), 32'd0);
        end
        i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        b_i_req = 0; b_d_wr = 0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_outs_a", 32'(|{i_rdy, i_data, d_rdy, d_rdata, mem_re, mem_we,
                                 mem_addr, mem_wdata, busy}), 32'd0);

        // Single fetch, store, then load of the stored value.
        run_a("fetch", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hB123);
        run_a("store", 1'b0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000);
        run_a("load",  1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);

        // Both sides request continuously: D, I, D, I, six cycles apart.
        i_req = 1'b1; i_addr = 16'h0010;
        d_rd = 1'b1; d_addr = 16'h0040;
        for (int g = 0; g < 4; g++) begin
            exp_addr = (g % 2 == 0) ? 16'h0040 : 16'h0010;
            tick();
            chk("both_grant", 32'(mem_addr), 32'(exp_addr));
            tick(); tick(); tick();
            tick();
            chk("both_rdy", 32'({i_rdy, d_rdy}), (g % 2 == 0) ? 32'b01 : 32'b10);
            chk("both_data", 32'((g % 2 == 0) ? d_rdata : i_data),
                (g % 2 == 0) ? 32'h0000BEEF : 32'h0000B123);
            tick();
            chk("both_idle", 32'(busy), 32'd0);
        end
        i_req = 1'b0; d_rd = 1'b0;
        tick();
        chk("both_done", 32'(busy), 32'd0);

        // rd+wr together is a write; address change mid-access is ignored.
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        tick();
        chk("rdwr_en", 32'({mem_re, mem_we}), 32'b01);
        d_addr = 16'h0077; d_wdata = 16'hFFFF;
        tick();
        chk("rdwr_addr", 32'(mem_addr), 32'h0040);
        chk("rdwr_wdata", 32'(mem_wdata), 32'h1234);
        tick(); tick();
        chk("rdwr_addr4", 32'(mem_addr), 32'h0040);
        tick();
        chk("rdwr_rdy", 32'({i_rdy, d_rdy}), 32'b01);
        chk("rdwr_rdata", 32'(d_rdata), 32'hBEEF);
        d_rd = 1'b0; d_wr = 1'b0;
        tick();
        run_a("load2", 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234);

        // Reset in the second DACC cycle aborts the access.
        d_wr = 1'b1; d_addr = 16'h0050; d_wdata = 16'h5555;
        tick();
        tick();
        chk("abort_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_state", 32'({busy, mem_we, mem_re, d_rdy}), 32'b0000);
        chk("abort_rdata", 32'(d_rdata), 32'h0000);
        rst_n = 1'b1; d_wr = 1'b0;
        rdy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            rdy_seen = rdy_seen | d_rdy | busy;
        end
        chk("abort_norsp", 32'(rdy_seen), 32'd0);

        // MEM_LAT = 1: ready two cycles after the request.
        b_i_req = 1'b1; b_i_addr = 16'h0010;
        chk("b_t0_re", 32'(b_mem_re), 32'd0);
        tick();
        chk("b_t1_re", 32'({b_mem_re, b_i_rdy}), 32'b10);
        chk("b_t1_addr", 32'(b_mem_addr), 32'h0010);
        tick();
        chk("b_t2_rdy", 32'({b_i_rdy, b_mem_re}), 32'b10);
        chk("b_t2_data", 32'(b_i_data), 32'hB123);
        b_i_req = 1'b0;
        tick();
        chk("b_idle", 32'({b_busy, b_i_rdy}), 32'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
